// File: rtl/sbqm_param.sv
// sbqm_param: bank-queue people counter with a sequential restoring divider for the waiting-time estimate.
// Optional macro SBQM_EDGE_DETECT_EN: synchronised, edge-triggered photocells (default build is level mode).
module sbqm_param #(
    parameter int DEPTH       = 7,
    parameter int TELLERS_MAX = 3,
    parameter int SVC_TIME    = 3,
    localparam int PW = $clog2(DEPTH + 1),
    localparam int TW = $clog2(TELLERS_MAX + 1),
    localparam int WW = $clog2(SVC_TIME * (DEPTH + TELLERS_MAX - 1) + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          front_photocell,
    input  logic          back_photocell,
    input  logic [TW-1:0] Tcount,
    output logic [PW-1:0] Pcount,
    output logic          empty_flag,
    output logic          full_flag,
    output logic [WW-1:0] Wtime,
    output logic          wtime_valid,
    output logic          reject_arrival,
    output logic          reject_depart,
    output logic          tcount_err
);

    localparam int            CW   = $clog2(WW + 1);
    localparam logic [PW-1:0] PMAX = PW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DIV,
        DONE
    } divState_e;

    function automatic logic illegalTellers(input logic [TW-1:0] t);
        return (t == '0) || (32'(t) > 32'(TELLERS_MAX));
    endfunction

    logic arrival;
    logic departure;

`ifdef SBQM_EDGE_DETECT_EN
    // Two-flop synchroniser per photocell plus a delayed copy; an event is a high-to-low transition.
    logic [1:0] backSync_q;
    logic [1:0] frontSync_q;
    logic       backPrev_q;
    logic       frontPrev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            backSync_q  <= 2'b11;
            frontSync_q <= 2'b11;
            backPrev_q  <= 1'b1;
            frontPrev_q <= 1'b1;
        end else begin
            backSync_q  <= {backSync_q[0], back_photocell};
            frontSync_q <= {frontSync_q[0], front_photocell};
            backPrev_q  <= backSync_q[1];
            frontPrev_q <= frontSync_q[1];
        end
    end

    assign arrival   = backPrev_q & ~backSync_q[1];
    assign departure = frontPrev_q & ~frontSync_q[1];
`else
    assign arrival   = ~back_photocell;
    assign departure = ~front_photocell;
`endif

    logic [PW-1:0] pcount_q;
    logic [PW-1:0] pcount_d;
    logic          rejArr_q;
    logic          rejArr_d;
    logic          rejDep_q;
    logic          rejDep_d;
    logic [TW-1:0] tcount_q;
    logic          tcountErr_q;

    always_comb begin
        pcount_d = pcount_q;
        rejArr_d = 1'b0;
        rejDep_d = 1'b0;
        if (arrival && departure) begin
            // A simultaneous pair only matters when the queue is empty: the leaver cannot exist yet.
            if (pcount_q == '0) begin
                pcount_d = PW'(1);
            end
        end else if (arrival) begin
            if (pcount_q != PMAX) begin
                pcount_d = pcount_q + 1'b1;
            end else begin
                rejArr_d = 1'b1;
            end
        end else if (departure) begin
            if (pcount_q != '0) begin
                pcount_d = pcount_q - 1'b1;
            end else begin
                rejDep_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcount_q    <= '0;
            rejArr_q    <= 1'b0;
            rejDep_q    <= 1'b0;
            tcount_q    <= Tcount;
            tcountErr_q <= 1'b0;
        end else begin
            pcount_q    <= pcount_d;
            rejArr_q    <= rejArr_d;
            rejDep_q    <= rejDep_d;
            tcount_q    <= Tcount;
            tcountErr_q <= illegalTellers(Tcount);
        end
    end

    divState_e     state_q;
    divState_e     state_d;
    logic [PW-1:0] snapP_q;
    logic [PW-1:0] snapP_d;
    logic [TW-1:0] snapT_q;
    logic [TW-1:0] snapT_d;
    logic [TW-1:0] rem_q;
    logic [TW-1:0] rem_d;
    logic [WW-1:0] quo_q;
    logic [WW-1:0] quo_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [WW-1:0] wtime_q;
    logic [WW-1:0] wtime_d;

    logic          changed;
    logic [TW:0]   divisorExt;
    logic [TW:0]   shifted;
    logic          fits;
    logic [TW-1:0] remNext;
    logic [WW-1:0] quoNext;
    logic [WW-1:0] dividend;

    assign changed = (pcount_q != snapP_q) || (tcount_q != snapT_q);

    // quo_q holds the dividend on entry; dividend bits shift out the top as quotient bits shift in.
    assign divisorExt = {1'b0, snapT_q};
    assign shifted    = {rem_q, quo_q[WW-1]};
    assign fits       = (shifted >= divisorExt);
    assign remNext    = fits ? TW'(shifted - divisorExt) : shifted[TW-1:0];
    assign quoNext    = {quo_q[WW-2:0], fits};
    assign dividend   = WW'(SVC_TIME * (int'(snapP_q) + int'(snapT_q) - 1));

    always_comb begin
        state_d = state_q;
        snapP_d = snapP_q;
        snapT_d = snapT_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        wtime_d = wtime_q;
        case (state_q)
            IDLE: begin
                if (changed) begin
                    state_d = LOAD;
                    snapP_d = pcount_q;
                    snapT_d = tcount_q;
                end
            end
            LOAD: begin
                if (changed) begin
                    snapP_d = pcount_q;
                    snapT_d = tcount_q;
                end else if (snapP_q == '0) begin
                    wtime_d = '0;
                    state_d = DONE;
                end else if (illegalTellers(snapT_q)) begin
                    wtime_d = '1;
                    state_d = DONE;
                end else begin
                    quo_d   = dividend;
                    rem_d   = '0;
                    cnt_d   = CW'(WW);
                    state_d = DIV;
                end
            end
            DIV: begin
                // A change mid-divide restarts from a fresh snapshot so no stale quotient is published.
                if (changed) begin
                    state_d = LOAD;
                    snapP_d = pcount_q;
                    snapT_d = tcount_q;
                end else begin
                    rem_d = remNext;
                    quo_d = quoNext;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        wtime_d = quoNext;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (changed) begin
                    state_d = LOAD;
                    snapP_d = pcount_q;
                    snapT_d = tcount_q;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            snapP_q <= '0;
            snapT_q <= Tcount;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            wtime_q <= '0;
        end else begin
            state_q <= state_d;
            snapP_q <= snapP_d;
            snapT_q <= snapT_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            wtime_q <= wtime_d;
        end
    end

    assign Pcount         = pcount_q;
    assign empty_flag     = (pcount_q == '0);
    assign full_flag      = (pcount_q == PMAX);
    assign Wtime          = wtime_q;
    assign wtime_valid    = ((state_q == IDLE) || (state_q == DONE)) && !changed;
    assign reject_arrival = rejArr_q;
    assign reject_depart  = rejDep_q;
    assign tcount_err     = tcountErr_q;

endmodule

// File: tb/tb_sbqm_param.sv
// tb_sbqm_param: directed stimulus for sbqm_param checked every cycle against a queue/formula model.
// Works in both photocell modes (SBQM_EDGE_DETECT_EN defined or not).
`timescale 1ns/1ps
module tb_sbqm_param;

    localparam int DEPTH = 7;
    localparam int TMAX  = 3;
    localparam int SVC   = 3;
    localparam int PW    = $clog2(DEPTH + 1);
    localparam int TW    = $clog2(TMAX + 1);
    localparam int WW    = $clog2(SVC * (DEPTH + TMAX - 1) + 1);
`ifdef SBQM_EDGE_DETECT_EN
    localparam bit EDGE_MODE = 1'b1;
`else
    localparam bit EDGE_MODE = 1'b0;
`endif
    localparam int EV_EXTRA = EDGE_MODE ? 2 : 0;

    logic          clk = 1'b0;
    logic          reset;
    logic          front;
    logic          back;
    logic [TW-1:0] tcnt;
    logic [PW-1:0] Pcount;
    logic          empty_flag;
    logic          full_flag;
    logic [WW-1:0] Wtime;
    logic          wtime_valid;
    logic          reject_arrival;
    logic          reject_depart;
    logic          tcount_err;

    int compared   = 0;
    int mismatched = 0;
    int rejACount  = 0;
    int rejDCount  = 0;

    always #5 clk = ~clk;

    sbqm_param #(
        .DEPTH      (DEPTH),
        .TELLERS_MAX(TMAX),
        .SVC_TIME   (SVC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .front_photocell(front),
        .back_photocell (back),
        .Tcount         (tcnt),
        .Pcount         (Pcount),
        .empty_flag     (empty_flag),
        .full_flag      (full_flag),
        .Wtime          (Wtime),
        .wtime_valid    (wtime_valid),
        .reject_arrival (reject_arrival),
        .reject_depart  (reject_depart),
        .tcount_err     (tcount_err)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Called at a falling edge; photocells return high after hold cycles, Tcount stays.
    task automatic applyStimulus(input logic f, input logic b, input logic [TW-1:0] t, input int hold);
        front = f;
        back  = b;
        tcnt  = t;
        repeat (hold) @(negedge clk);
        front = 1'b1;
        back  = 1'b1;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Counts falling edges until wtime_valid; expected < 0 means just wait.
    task automatic measureLatency(input string name, input int expected);
        int  cyc;
        bit  seen;
        seen = 1'b0;
        for (cyc = 1; cyc <= 64; cyc++) begin
            @(negedge clk);
            if (wtime_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s: wtime_valid never rose, got 0, expected 1", name);
        end else if (expected >= 0) begin
            checkOutput(name, cyc, expected);
        end
    endtask

    function automatic int expW(input int p, input int t, input bit e);
        if (p == 0) return 0;
        if (e || t == 0) return (1 << WW) - 1;
        return (SVC * (p + t - 1)) / t;
    endfunction

    // Reference model: queue occupancy from photocell events, registered teller count and error.
    int mP;
    int mTq;
    int prevP;
    int prevT;
    bit mErr;
    bit mRejA;
    bit mRejD;
    bit mWasReset;
    bit arr;
    bit dep;
    bit bH[4];
    bit fH[4];

    always @(posedge clk) begin
        mWasReset = reset;
        if (reset) begin
            mP    = 0;
            mTq   = int'(tcnt);
            mErr  = 1'b0;
            mRejA = 1'b0;
            mRejD = 1'b0;
            for (int i = 0; i < 4; i++) begin
                bH[i] = 1'b1;
                fH[i] = 1'b1;
            end
        end else begin
            for (int i = 3; i > 0; i--) begin
                bH[i] = bH[i-1];
                fH[i] = fH[i-1];
            end
            bH[0] = back;
            fH[0] = front;
            if (EDGE_MODE) begin
                arr = !bH[2] && bH[3];
                dep = !fH[2] && fH[3];
            end else begin
                arr = !back;
                dep = !front;
            end
            mRejA = 1'b0;
            mRejD = 1'b0;
            if (arr && dep) begin
                if (mP == 0) mP = 1;
            end else if (arr) begin
                if (mP < DEPTH) mP = mP + 1;
                else mRejA = 1'b1;
            end else if (dep) begin
                if (mP > 0) mP = mP - 1;
                else mRejD = 1'b1;
            end
            mTq  = int'(tcnt);
            mErr = (mTq == 0) || (mTq > TMAX);
        end
        #2;
        checkOutput("Pcount", int'(Pcount), mP);
        checkOutput("empty_flag", int'(empty_flag), int'(mP == 0));
        checkOutput("full_flag", int'(full_flag), int'(mP == DEPTH));
        checkOutput("reject_arrival", int'(reject_arrival), int'(mRejA));
        checkOutput("reject_depart", int'(reject_depart), int'(mRejD));
        checkOutput("tcount_err", int'(tcount_err), int'(mErr));
        if (mWasReset) begin
            checkOutput("reset wtime_valid", int'(wtime_valid), 1);
            checkOutput("reset Wtime", int'(Wtime), 0);
        end else if (mP != prevP || mTq != prevT) begin
            checkOutput("wtime_valid drop", int'(wtime_valid), 0);
        end else if (wtime_valid) begin
            checkOutput("Wtime", int'(Wtime), expW(mP, mTq, mErr));
        end
        prevP = mP;
        prevT = mTq;
        if (reject_arrival) rejACount++;
        if (reject_depart) rejDCount++;
    end

    task automatic pulses(input logic f, input logic b, input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(f, b, tcnt, 1);
            @(negedge clk);
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        front = 1'b1;
        back  = 1'b1;
        tcnt  = TW'(2);
        @(negedge clk);
        checkOutput("rst Pcount", int'(Pcount), 0);
        checkOutput("rst empty", int'(empty_flag), 1);
        checkOutput("rst full", int'(full_flag), 0);
        checkOutput("rst Wtime", int'(Wtime), 0);
        checkOutput("rst valid", int'(wtime_valid), 1);
        reset = 1'b0;
        $display("[TB] reset checked, filling queue");

        rejACount = 0;
        pulses(1'b1, 1'b0, 8);
        settle(4);
        checkOutput("fill Pcount", int'(Pcount), 7);
        checkOutput("fill full", int'(full_flag), 1);
        checkOutput("fill reject count", rejACount, 1);
        measureLatency("fill wait", -1);
        checkOutput("fill Wtime P7 T2", int'(Wtime), 12);

        pulses(1'b0, 1'b1, 4);
        settle(4);
        measureLatency("drain wait", -1);
        checkOutput("drain Pcount", int'(Pcount), 3);
        applyStimulus(1'b1, 1'b1, TW'(1), 1);
        measureLatency("latency T1", 7);
        checkOutput("Wtime P3 T1", int'(Wtime), 9);
        applyStimulus(1'b1, 1'b1, TW'(3), 1);
        measureLatency("latency T3", 7);
        checkOutput("Wtime P3 T3", int'(Wtime), 5);
        applyStimulus(1'b1, 1'b0, TW'(3), 1);
        measureLatency("latency arrival", 7 + EV_EXTRA);
        checkOutput("Wtime P4 T3", int'(Wtime), 6);
        applyStimulus(1'b1, 1'b1, TW'(2), 1);
        measureLatency("latency T2", 7);
        checkOutput("Wtime P4 T2 floor", int'(Wtime), 7);

        $display("[TB] teller error and reset abort");
        applyStimulus(1'b1, 1'b1, TW'(0), 1);
        measureLatency("latency terr", 2);
        checkOutput("terr flag", int'(tcount_err), 1);
        checkOutput("terr Wtime", int'(Wtime), 31);
        applyStimulus(1'b1, 1'b1, TW'(2), 1);
        settle(2);
        checkOutput("mid-divide valid low", int'(wtime_valid), 0);
        doReset();
        checkOutput("abort Wtime", int'(Wtime), 0);
        checkOutput("abort valid", int'(wtime_valid), 1);
        checkOutput("abort Pcount", int'(Pcount), 0);

        $display("[TB] simultaneous events");
        rejACount = 0;
        rejDCount = 0;
        applyStimulus(1'b0, 1'b0, TW'(2), 1);
        settle(4);
        checkOutput("both at 0 Pcount", int'(Pcount), 1);
        checkOutput("both at 0 rejects", rejACount + rejDCount, 0);
        pulses(1'b1, 1'b0, 6);
        settle(4);
        checkOutput("refill Pcount", int'(Pcount), 7);
        applyStimulus(1'b0, 1'b0, TW'(2), 1);
        settle(4);
        checkOutput("both at 7 Pcount", int'(Pcount), 7);
        checkOutput("both at 7 rejects", rejACount + rejDCount, 0);

        doReset();
        rejDCount = 0;
        pulses(1'b0, 1'b1, 1);
        settle(4);
        checkOutput("underflow Pcount", int'(Pcount), 0);
        checkOutput("underflow reject count", rejDCount, 1);

        $display("[TB] held-low back photocell");
        rejACount = 0;
        applyStimulus(1'b1, 1'b0, TW'(2), 9);
        settle(4);
        checkOutput("hold Pcount", int'(Pcount), EDGE_MODE ? 1 : 7);
        checkOutput("hold reject count", rejACount, EDGE_MODE ? 0 : 2);
        measureLatency("final wait", -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/sbqm_param.md
SBQM_PARAM -- requirements
Module: sbqm_param

Interface
REQ-001 Parameter DEPTH, default 7: maximum customers held in the queue.
REQ-002 Parameter TELLERS_MAX, default 3: maximum legal teller count.
REQ-003 Parameter SVC_TIME, default 3: service time per customer, in time units.
REQ-004 Derived widths: PW=clog2(DEPTH+1), TW=clog2(TELLERS_MAX+1), WW=clog2(SVC_TIME*(DEPTH+TELLERS_MAX-1)+1); defaults give 3/2/5.
REQ-005 clk  in  1  the only clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 front_photocell  in  1  active low; customer leaves at the teller end.
REQ-008 back_photocell  in  1  active low; customer enters at the queue end.
REQ-009 Tcount  in  TW  number of open tellers.
REQ-010 Pcount  out  PW  customers currently in the queue.
REQ-011 empty_flag / full_flag  out  1  high when Pcount==0 / Pcount==DEPTH; decoded from registered Pcount.
REQ-012 Wtime  out  WW  estimated waiting time.
REQ-013 wtime_valid  out  1  high when Wtime matches the current Pcount and Tcount.
REQ-014 reject_arrival / reject_depart  out  1  one-cycle pulse when an event is dropped.
REQ-015 tcount_err  out  1  high while Tcount==0 or Tcount>TELLERS_MAX (registered).

Function
REQ-016 Arrival event alone: Pcount+1 if Pcount<DEPTH, else unchanged and reject_arrival pulses.
REQ-017 Departure event alone: Pcount-1 if Pcount>0, else unchanged and reject_depart pulses.
REQ-018 Both events, 0<Pcount<DEPTH: Pcount unchanged, no reject.
REQ-019 Both events, Pcount==0: Pcount becomes 1; departure is ignored with no reject pulse.
REQ-020 Both events, Pcount==DEPTH: Pcount unchanged, no reject pulse.
REQ-021 Pcount never wraps past 0 or DEPTH.
REQ-022 Wtime rule when Pcount==0: Wtime is 0.
REQ-023 Wtime rule when Pcount>0 and Tcount is legal: Wtime=floor(SVC_TIME*(Pcount+Tcount-1)/Tcount).
REQ-024 Wtime rule when tcount_err is high: Wtime saturates to all ones.
REQ-025 Wtime is computed by a sequential restoring divider, one quotient bit per cycle.
REQ-026 Divider FSM states: IDLE, LOAD, DIV, DONE.
REQ-027 IDLE->LOAD when registered Pcount or Tcount differs from the last snapshot; LOAD captures the snapshot.
REQ-028 LOAD->DIV; DIV runs WW cycles; DIV->DONE; DONE writes Wtime, asserts wtime_valid and returns to IDLE.
REQ-029 Zero and error cases skip DIV: LOAD->DONE.
REQ-030 wtime_valid drops on the cycle the change is detected; Wtime holds its old value until DONE.
REQ-031 If inputs change in LOAD or DIV, the divide is aborted and restarts in LOAD on the next cycle; no stale result is published.
REQ-032 Timing: Wtime is published WW+2 clocks after change detection for a division, 2 clocks for zero/error cases.

Reset
REQ-033 Reset values: Pcount=0, empty_flag=1, full_flag=0, Wtime=0, wtime_valid=1, reject_* =0, tcount_err=0.
REQ-034 Reset also clears the FSM (IDLE), the snapshot (Pcount 0, current Tcount) and the synchroniser/edge flops (to high).
REQ-035 Reset has priority over all events and aborts any division in progress.

Configuration
REQ-036 Macro SBQM_EDGE_DETECT_EN defined: each photocell passes through a 2-flop synchroniser plus an edge register.
REQ-037 With SBQM_EDGE_DETECT_EN, one event per falling edge; Pcount updates 3 clocks after the photocell falls; a held-low level counts once.
REQ-038 Without SBQM_EDGE_DETECT_EN: legacy level mode; every clock a photocell is sampled low is one event; Pcount updates at the next edge.

Verification
REQ-039 Reset asserted 1 clock -> Pcount=0, empty=1, full=0, Wtime=0, wtime_valid=1.
REQ-040 Defaults, edge mode, Tcount=2, 8 back pulses -> Pcount=7, full=1, one reject_arrival on the 8th pulse, Wtime=12 once valid.
REQ-041 Pcount=3: Tcount=1 -> Wtime=9; Tcount=3 -> Wtime=5; each published WW+2=7 clocks after the change.
REQ-042 Simultaneous front+back falling edges: at Pcount=0 -> 1, no reject; at Pcount=7 -> stays 7, no reject.
REQ-043 Tcount=0 with Pcount=4 -> tcount_err=1, Wtime=31, wtime_valid=1 within 2 clocks; reset asserted mid-division -> Wtime=0, wtime_valid=1 next clock.
REQ-044 Level mode (macro undefined), back_photocell low 9 clocks -> Pcount=7 after 7 clocks, reject_arrival high for the last 2.
